// File: rtl/ami_mem_responder_pkg.sv
// AMITypes: shared types for the AMI memory responder.
//   AMIRequest  - request bus word (valid, isWrite, byte addr, 512b data, size in bytes)
//   AMIResponse - response bus word (valid, 512b data, size in bytes)
//   resp_state_e - responder control states (memory clear sweep, normal operation)
//   word_we()   - 64-bit lane write enables for a write of the given size/word
package AMITypes;

   localparam logic [63:0] AMI_BLOCK_BYTES = 64'd64;
   localparam logic [63:0] AMI_WORD_BYTES  = 64'd8;

   typedef struct packed {
      logic         valid;
      logic         isWrite;
      logic [63:0]  addr;
      logic [511:0] data;
      logic [63:0]  size;
   } AMIRequest;

   typedef struct packed {
      logic         valid;
      logic [511:0] data;
      logic [63:0]  size;
   } AMIResponse;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } resp_state_e;

   // Unsupported sizes enable no lanes, which is how such writes get dropped.
   function automatic logic [7:0] word_we(input logic [63:0] size, input logic [2:0] word);
      if (size == AMI_BLOCK_BYTES) return 8'hFF;
      if (size == AMI_WORD_BYTES)  return 8'b1 << word;
      return 8'h00;
   endfunction

endpackage

// File: rtl/ami_mem_responder_if.sv
// AMI request/response bus between a requester (master) and the memory
// responder (slave).
//   reqIn         - request from master
//   reqIn_grant   - request accepted this cycle (from slave)
//   respOut       - head response (from slave)
//   respOut_grant - master pops the head response this cycle
interface ami_mem_responder_if;
   import AMITypes::*;

   AMIRequest  reqIn;
   logic       reqIn_grant;
   AMIResponse respOut;
   logic       respOut_grant;

   modport master (
      output reqIn,
      output respOut_grant,
      input  reqIn_grant,
      input  respOut
   );

   modport slave (
      input  reqIn,
      input  respOut_grant,
      output reqIn_grant,
      output respOut
   );

endinterface

// File: rtl/ami_resp_fifo.sv
// Response queue for the AMI memory responder: 2^LOG_Q_SIZE entries of
// AMIResponse, first-word-fall-through head.
//   clk, rst     - clock, synchronous active-high reset (empties the queue)
//   push_i       - write push_data_i at the tail
//   pop_i        - drop the head entry (ignored while empty)
//   head_o       - current head entry (undefined while empty)
//   empty_o      - queue holds no entries
//   count_o      - number of entries held
module ami_resp_fifo
   import AMITypes::*;
#(
   parameter int LOG_Q_SIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push_i,
   input  AMIResponse          push_data_i,
   input  logic                pop_i,
   output AMIResponse          head_o,
   output logic                empty_o,
   output logic [LOG_Q_SIZE:0] count_o
);

   localparam int DEPTH = 1 << LOG_Q_SIZE;

   AMIResponse            mem_q [DEPTH];
   logic [LOG_Q_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_Q_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG_Q_SIZE:0]   count_q, count_d;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == (LOG_Q_SIZE+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the slot in the same cycle, so a full queue still takes a push.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (LOG_Q_SIZE+1)'(do_push) - (LOG_Q_SIZE+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ami_mem_responder.sv
// AMI memory responder: a 2^LOG_DEPTH x 64-byte RAM that serves AMI reads
// and writes, returning read responses in order through a response queue.
// After reset the RAM is swept to zero, one block per cycle, before any
// request is granted.
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - AMI request/response bus (slave side)
//   init_done - memory clear finished; requests may be granted
//   bad_size  - sticky: an accepted request had a size other than 8 or 64
module ami_mem_responder
   import AMITypes::*;
#(
   parameter int LOG_DEPTH  = 10,
   parameter int LOG_Q_SIZE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   ami_mem_responder_if.slave     bus,
   output logic                   init_done,
   output logic                   bad_size
);

   localparam int DEPTH     = 1 << LOG_DEPTH;
   localparam int Q_ENTRIES = 1 << LOG_Q_SIZE;
   localparam int OW        = LOG_Q_SIZE + 2;

   resp_state_e            state_q;
   logic [LOG_DEPTH-1:0]   sweep_q;
   logic                   bad_size_q;

   logic [511:0]           ram [DEPTH];
   logic [LOG_DEPTH-1:0]   ram_addr;
   logic [7:0]             ram_we;
   logic [511:0]           ram_wdata;
   logic [511:0]           ram_rdata_q;

   logic                   vld_p1_q;
   logic [2:0]             word_p1_q;
   logic [63:0]            size_p1_q;

   AMIResponse             push_resp;
   AMIResponse             fifo_head;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [LOG_Q_SIZE:0]    fifo_count;
   logic [OW-1:0]          outstanding;

   logic [LOG_DEPTH-1:0]   req_blk;
   logic [2:0]             req_word;
   logic                   size_bad;
   logic                   accept;
   logic                   unused_addr;

   assign req_blk  = bus.reqIn.addr[LOG_DEPTH+5:6];
   assign req_word = bus.reqIn.addr[5:3];
   assign size_bad = (bus.reqIn.size != AMI_BLOCK_BYTES) && (bus.reqIn.size != AMI_WORD_BYTES);
   // Upper address bits wrap; the byte offset within a word is irrelevant.
   assign unused_addr = ^{bus.reqIn.addr[63:LOG_DEPTH+6], bus.reqIn.addr[2:0]};

   // Queue entries plus the read in flight, less the entry leaving this cycle.
   assign fifo_pop    = bus.respOut_grant && !fifo_empty;
   assign outstanding = OW'(fifo_count) + OW'(vld_p1_q) - OW'(fifo_pop);
   assign accept      = !rst && (state_q == ST_RUN) && bus.reqIn.valid &&
                        (outstanding < OW'(Q_ENTRIES));
   assign bus.reqIn_grant = accept;

   // Control FSM: zero sweep, then normal operation with the sticky size flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         sweep_q    <= '0;
         bad_size_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == '1) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (accept && size_bad) bad_size_q <= 1'b1;
            end
         endcase
      end
   end

   assign init_done = !rst && (state_q == ST_RUN);
   assign bad_size  = !rst && bad_size_q;

   // Single RAM port: the zero sweep owns it during INIT, the accepted request afterwards.
   always_comb begin
      ram_addr  = req_blk;
      ram_we    = '0;
      ram_wdata = (bus.reqIn.size == AMI_BLOCK_BYTES) ? bus.reqIn.data
                                                      : {8{bus.reqIn.data[63:0]}};
      if (state_q == ST_INIT) begin
         ram_addr  = sweep_q;
         ram_we    = '1;
         ram_wdata = '0;
      end else if (accept && bus.reqIn.isWrite) begin
         ram_we = word_we(bus.reqIn.size, req_word);
      end
   end

   // Stage p0 -> p1: RAM access in the accept cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (ram_we[i]) ram[ram_addr][i*64 +: 64] <= ram_wdata[i*64 +: 64];
      end
      ram_rdata_q <= ram[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= accept && !bus.reqIn.isWrite;
   end

   always_ff @(posedge clk) begin
      word_p1_q <= req_word;
      size_p1_q <= bus.reqIn.size;
   end

   // Stage p1 -> queue: shape the read data by size and push.
   always_comb begin
      push_resp       = '0;
      push_resp.valid = 1'b1;
      push_resp.size  = size_p1_q;
      if (size_p1_q == AMI_BLOCK_BYTES) begin
         push_resp.data = ram_rdata_q;
      end else if (size_p1_q == AMI_WORD_BYTES) begin
         push_resp.data[63:0] = ram_rdata_q[{word_p1_q, 6'b0} +: 64];
      end
   end

   ami_resp_fifo #(
      .LOG_Q_SIZE (LOG_Q_SIZE)
   ) u_resp_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (vld_p1_q),
      .push_data_i (push_resp),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Queue output: zeros whenever nothing is valid or reset is asserted.
   always_comb begin
      bus.respOut = '0;
      if (!rst && !fifo_empty) bus.respOut = fifo_head;
   end

endmodule

// File: tb/tb_ami_mem_responder.sv
module tb_ami_mem_responder;
   import AMITypes::*;

   localparam int NBLK = 1024;
   localparam int QN   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_done;
   logic bad_size;

   ami_mem_responder_if bus ();

   ami_mem_responder #(
      .LOG_DEPTH  (10),
      .LOG_Q_SIZE (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .init_done (init_done),
      .bad_size  (bad_size)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int since_rst = 0;
   logic model_bad = 1'b0;
   logic [511:0] model_mem [NBLK];

   typedef struct {
      AMIResponse r;
      int         ready;
   } exp_t;
   exp_t       exp_q [$];
   AMIResponse got_q [$];

   typedef struct {
      logic         isWrite;
      logic [63:0]  addr;
      logic [511:0] data;
      logic [63:0]  size;
      logic [511:0] exp_data;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 512'(act), 512'(exp));
   endtask

   function automatic AMIRequest mk(input logic w, input logic [63:0] a,
                                    input logic [511:0] d, input logic [63:0] s);
      AMIRequest r;
      r.valid = 1'b1; r.isWrite = w; r.addr = a; r.data = d; r.size = s;
      return r;
   endfunction

   function automatic vec_t mkv(input logic w, input logic [63:0] a, input logic [511:0] d,
                                input logic [63:0] s, input logic [511:0] e);
      vec_t v;
      v.isWrite = w; v.addr = a; v.data = d; v.size = s; v.exp_data = e;
      return v;
   endfunction

   // Reference model: block = (addr/64) mod NBLK, word = (addr mod 64)/8.
   function automatic AMIResponse model_read(input logic [63:0] addr, input logic [63:0] size);
      AMIResponse r;
      int b, w;
      b = int'((addr / 64) % NBLK);
      w = int'((addr % 64) / 8);
      r.valid = 1'b1; r.size = size; r.data = '0;
      if (size == 64)     r.data = model_mem[b];
      else if (size == 8) r.data[63:0] = model_mem[b][w*64 +: 64];
      return r;
   endfunction

   task automatic model_write(input AMIRequest rq);
      int b, w;
      b = int'((rq.addr / 64) % NBLK);
      w = int'((rq.addr % 64) / 8);
      if (rq.size == 64)     model_mem[b] = rq.data;
      else if (rq.size == 8) model_mem[b][w*64 +: 64] = rq.data[63:0];
   endtask

   // One clock: drive, check every output against the model, advance the model.
   task automatic cycle(input logic r, input AMIRequest rq, input logic pop, output logic granted);
      logic exp_valid, exp_grant;
      int occ;
      exp_valid = 1'b0; exp_grant = 1'b0;
      rst = r; bus.reqIn = rq; bus.respOut_grant = pop;
      @(negedge clk);
      if (r) begin
         chk1("rst_grant", bus.reqIn_grant, 1'b0);
         chk1("rst_valid", bus.respOut.valid, 1'b0);
         chk("rst_data", bus.respOut.data, '0);
         chk("rst_size", 512'(bus.respOut.size), '0);
         chk1("rst_init_done", init_done, 1'b0);
         chk1("rst_bad_size", bad_size, 1'b0);
      end else begin
         exp_valid = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
         chk1("init_done", init_done, since_rst >= NBLK);
         chk1("bad_size", bad_size, model_bad);
         chk1("resp_valid", bus.respOut.valid, exp_valid);
         if (exp_valid) begin
            chk("resp_data", bus.respOut.data, exp_q[0].r.data);
            chk("resp_size", 512'(bus.respOut.size), 512'(exp_q[0].r.size));
         end
         occ = exp_q.size() - ((pop && exp_valid) ? 1 : 0);
         exp_grant = (since_rst >= NBLK) && rq.valid && (occ < QN);
         chk1("req_grant", bus.reqIn_grant, exp_grant);
      end
      granted = bus.reqIn_grant;
      if (bus.respOut.valid && pop) got_q.push_back(bus.respOut);
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         foreach (model_mem[i]) model_mem[i] = '0;
         since_rst = 0;
         model_bad = 1'b0;
      end else begin
         if (pop && exp_valid) void'(exp_q.pop_front());
         if (exp_grant) begin
            if (rq.size != 8 && rq.size != 64) model_bad = 1'b1;
            if (rq.isWrite) model_write(rq);
            else exp_q.push_back('{model_read(rq.addr, rq.size), cyc + 2});
         end
         if (since_rst < NBLK) since_rst++;
      end
      cyc++;
      #1;
   endtask

   task automatic send(input AMIRequest rq);
      logic g;
      int n;
      g = 1'b0; n = 0;
      while (!g && n < 64) begin
         cycle(1'b0, rq, 1'b1, g);
         n++;
      end
      if (!g) chk("send_grant_timeout", 512'(0), 512'(1));
   endtask

   task automatic drain();
      logic g;
      int n;
      AMIRequest idle;
      idle = '0; n = 0;
      while (exp_q.size() > 0 && n < 64) begin
         cycle(1'b0, idle, 1'b1, g);
         n++;
      end
      cycle(1'b0, idle, 1'b1, g);
      chk("drain_empty", 512'(exp_q.size()), 512'(0));
   endtask

   // Reset, then 1024 cycles of offered reads that must not be granted.
   task automatic do_init();
      logic g;
      AMIRequest rd;
      rd = mk(1'b0, 64'h40, '0, 64'd8);
      repeat (2) cycle(1'b1, rd, 1'b1, g);
      for (int i = 0; i < NBLK; i++) begin
         cycle(1'b0, rd, 1'b1, g);
         if (i == 0) chk1("post_rst_valid", bus.respOut.valid, 1'b0);
         if (i == NBLK - 2) chk1("init_done_at_1023", init_done, 1'b0);
      end
      chk1("init_done_at_1024", init_done, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [511:0] blk_c, blk_p;
      logic         g;
      int           n, k;
      AMIRequest    rq, idle;
      AMIResponse   snap;

      idle = '0;
      bus.reqIn = '0;
      bus.respOut_grant = 1'b0;

      for (int i = 0; i < 8; i++) begin
         blk_c[i*64 +: 64] = 64'hCBBABAABDEAD0000 + 64'(i);
         blk_p[i*64 +: 64] = 64'h0123456789ABCDEF ^ 64'(i * 7 + 1);
      end
      for (int i = 0; i < 8; i++)
         tbl.push_back(mkv(1'b1, 64'(i * 8), 512'(64'hABBABAABDEAD0000 + 64'(i)), 64'd8, '0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mkv(1'b0, 64'(i * 8), '0, 64'd8, 512'(64'hABBABAABDEAD0000 + 64'(i))));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mkv(1'b1, 64'h40 + 64'(i * 8), 512'(blk_c[i*64 +: 64]), 64'd8, '0));
      tbl.push_back(mkv(1'b0, 64'h40,    '0, 64'd64, blk_c));
      tbl.push_back(mkv(1'b0, 64'h10040, '0, 64'd64, blk_c));
      tbl.push_back(mkv(1'b0, 64'h40,    '0, 64'd4,  '0));
      tbl.push_back(mkv(1'b0, 64'h38,    '0, 64'd8,  512'(64'hABBABAABDEAD0007)));
      tbl.push_back(mkv(1'b1, 64'h80,    blk_p, 64'd64, '0));
      tbl.push_back(mkv(1'b0, 64'h88,    '0, 64'd8,  512'(blk_p[127:64])));
      tbl.push_back(mkv(1'b1, 64'h80,    '1, 64'd16, '0));
      tbl.push_back(mkv(1'b0, 64'h80,    '0, 64'd64, blk_p));

      do_init();

      // Table-driven directed vectors.
      got_q.delete();
      foreach (tbl[i]) send(mk(tbl[i].isWrite, tbl[i].addr, tbl[i].data, tbl[i].size));
      drain();
      k = 0;
      foreach (tbl[i]) begin
         if (!tbl[i].isWrite) begin
            if (k < got_q.size()) begin
               chk($sformatf("tbl%0d_data", i), got_q[k].data, tbl[i].exp_data);
               chk($sformatf("tbl%0d_size", i), 512'(got_q[k].size), 512'(tbl[i].size));
            end
            k++;
         end
      end
      chk("tbl_resp_count", 512'(got_q.size()), 512'(k));
      chk1("bad_size_sticky", bad_size, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rq.valid   = ($urandom % 4) != 0;
         rq.isWrite = $urandom % 2;
         rq.addr    = {$urandom(), $urandom()};
         rq.addr[15:6] = 10'($urandom % 6);
         for (int j = 0; j < 16; j++) rq.data[j*32 +: 32] = $urandom();
         case ($urandom % 8)
            0, 1, 2: rq.size = 64'd8;
            3, 4, 5: rq.size = 64'd64;
            6:       rq.size = 64'd4;
            default: rq.size = 64'd32;
         endcase
         cycle(1'b0, rq, ($urandom % 3) != 0, g);
      end
      drain();

      // Back-pressure: 20 reads with no pops, then one pop frees one grant.
      n = 0;
      snap = '0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, mk(1'b0, 64'(i * 8), '0, 64'd8), 1'b0, g);
         if (g) n++;
         if (i == 4) snap = bus.respOut;
      end
      chk("burst_grants", 512'(n), 512'(16));
      chk1("burst_head_valid", bus.respOut.valid, 1'b1);
      chk("burst_head_stable", bus.respOut.data, snap.data);
      cycle(1'b0, mk(1'b0, 64'h8, '0, 64'd8), 1'b1, g);
      chk1("grant_with_pop", g, 1'b1);
      drain();

      // Reset with five responses queued; memory must come back as zero.
      for (int i = 0; i < 5; i++) cycle(1'b0, mk(1'b0, 64'(i * 8), '0, 64'd8), 1'b0, g);
      repeat (3) cycle(1'b0, idle, 1'b0, g);
      chk1("queued_before_rst", bus.respOut.valid, 1'b1);
      do_init();
      got_q.delete();
      send(mk(1'b0, 64'h00, '0, 64'd8));
      send(mk(1'b0, 64'h40, '0, 64'd64));
      send(mk(1'b0, 64'h80, '0, 64'd64));
      drain();
      chk("post_rst_count", 512'(got_q.size()), 512'(3));
      foreach (got_q[i]) chk($sformatf("post_rst_rd%0d_zero", i), got_q[i].data, '0);
      chk1("post_rst_bad_clear", bad_size, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
